// File: rtl/ahb_sram_sub.sv
// AHB subordinate over a word-addressed register-file memory; data phase lasts 1+WaitStates cycles (ERROR: 2).
// Stalls the bus only by holding readyOut low in WAIT/ERR1; address phases are taken only when the previous data phase is completing.
module ahb_sram_sub #(
  parameter int DataWidth  = 32,
  parameter int AddrWidth  = 32,
  parameter int Depth      = 256,
  parameter int WaitStates = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sel,
  input  logic [AddrWidth-1:0]   addr,
  input  logic                   write,
  input  logic [2:0]             size,
  input  logic [1:0]             trans,
  input  logic                   ready,
  input  logic [DataWidth-1:0]   wData,
  input  logic [DataWidth/8-1:0] wStrb,
  output logic                   readyOut,
  output logic                   resp,
  output logic [DataWidth-1:0]   rData
);

  localparam int ByteW    = DataWidth / 8;
  localparam int LaneBits = $clog2(ByteW);
  localparam int IdxW     = $clog2(Depth);
  localparam int TopBit   = LaneBits + IdxW;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_XFER,
    S_ERR1,
    S_ERR2
  } state_t;

  typedef struct packed {
    logic [IdxW-1:0] idx;
    logic            wr;
  } aph_t;

  logic [DataWidth-1:0] mem [Depth];

  state_t               state_q, state_d, target;
  aph_t                 aph_q;
  logic [3:0]           cnt_q;
  logic                 phase_open, accept, legal;
  logic                 size_ok, align_ok, range_ok;
  logic [LaneBits-1:0]  lane_mask;
  logic                 unused_trans;

  assign unused_trans = trans[0];

  // A new address phase can only land while the current data phase is completing.
  assign phase_open = (state_q == S_IDLE) || (state_q == S_XFER) || (state_q == S_ERR2);
  assign accept     = sel && ready && trans[1] && phase_open;

  assign size_ok   = size <= 3'(LaneBits);
  assign lane_mask = LaneBits'((32'd1 << size) - 32'd1);
  assign align_ok  = (addr[LaneBits-1:0] & lane_mask) == '0;
  assign range_ok  = addr[AddrWidth-1:TopBit] == '0;
  assign legal     = size_ok && align_ok && range_ok;

  always_comb begin
    target = S_XFER;
    if (!legal) begin
      target = S_ERR1;
    end else if (WaitStates > 0) begin
      target = S_WAIT;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      aph_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        aph_q.idx <= addr[LaneBits +: IdxW];
        aph_q.wr  <= write;
      end
      if (accept && legal) begin
        cnt_q <= 4'(WaitStates);
      end else if (state_q == S_WAIT && cnt_q != '0) begin
        cnt_q <= cnt_q - 4'd1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    readyOut = 1'b1;
    resp     = 1'b0;
    rData    = '0;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = target;
      end
      S_WAIT: begin
        readyOut = 1'b0;
        if (cnt_q == 4'd1) state_d = S_XFER;
      end
      S_XFER: begin
        if (!aph_q.wr) rData = mem[aph_q.idx];
        state_d = accept ? target : S_IDLE;
      end
      S_ERR1: begin
        readyOut = 1'b0;
        resp     = 1'b1;
        state_d  = S_ERR2;
      end
      S_ERR2: begin
        resp    = 1'b1;
        state_d = accept ? target : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Commit on the edge closing XFER so a read accepted in that cycle sees the new word.
  always_ff @(posedge clk) begin
    if (state_q == S_XFER && aph_q.wr) begin
      for (int i = 0; i < ByteW; i++) begin
        if (wStrb[i]) mem[aph_q.idx][8*i +: 8] <= wData[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ahb_sram_sub.sv
// Two subordinates (0 and 3 wait states) on one AHB bus; a monitor scores each completed data phase.
module tb_ahb_sram_sub;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
    logic [3:0]  waits;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel0, sel3, write, ready;
  logic [31:0] addr, wdata;
  logic [2:0]  size;
  logic [1:0]  trans;
  logic [3:0]  wstrb;
  logic        ro0, ro3, rsp0, rsp3;
  logic [31:0] rd0, rd3;

  int   tests = 0;
  int   fails = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  assign ready = ro0 & ro3;

  ahb_sram_sub #(.DataWidth(32), .AddrWidth(32), .Depth(256), .WaitStates(0)) dut0 (
    .clk(clk), .reset(reset), .sel(sel0), .addr(addr), .write(write), .size(size),
    .trans(trans), .ready(ready), .wData(wdata), .wStrb(wstrb),
    .readyOut(ro0), .resp(rsp0), .rData(rd0)
  );

  ahb_sram_sub #(.DataWidth(32), .AddrWidth(32), .Depth(256), .WaitStates(3)) dut3 (
    .clk(clk), .reset(reset), .sel(sel3), .addr(addr), .write(write), .size(size),
    .trans(trans), .ready(ready), .wData(wdata), .wStrb(wstrb),
    .readyOut(ro3), .resp(rsp3), .rData(rd3)
  );

  // Monitor: samples mid-cycle, tracks the data phase of whichever subordinate was selected.
  logic in_dp = 1'b0;
  logic dsel  = 1'b0;
  int   stall = 0;
  int   n_done = 0;
  logic low_all1, low_any1, low_rdnz;

  always @(negedge clk) begin : mon
    logic        r, rs, ok;
    logic [31:0] rd;
    exp_t        e;
    r  = dsel ? ro3  : ro0;
    rs = dsel ? rsp3 : rsp0;
    rd = dsel ? rd3  : rd0;
    if (reset) begin
      tests++;
      if (!(ro0 && ro3 && !rsp0 && !rsp3 && rd0 == 32'h0 && rd3 == 32'h0)) begin
        fails++;
        $display("FAIL reset_outputs: got ready=%b/%b resp=%b/%b rdata=%h/%h, required ready=1 resp=0 rdata=0",
                 ro0, ro3, rsp0, rsp3, rd0, rd3);
      end
      if (in_dp && q.size() > 0) void'(q.pop_front());
      in_dp = 1'b0;
    end else begin
      if (in_dp) begin
        if (!r) begin
          stall++;
          if (rs) low_any1 = 1'b1; else low_all1 = 1'b0;
          if (rd != 32'h0) low_rdnz = 1'b1;
          if (stall > 40) begin
            tests++;
            fails++;
            $display("FAIL dphase_timeout: got ready=0 for %0d cycles, required completion", stall);
            in_dp = 1'b0;
          end
        end else begin
          in_dp = 1'b0;
          tests++;
          if (q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_dphase: got completion resp=%b rdata=%h, required none", rs, rd);
          end else begin
            e = q.pop_front();
            if (e.err) ok = rs && stall == 1 && low_all1 && rd == 32'h0;
            else       ok = !rs && stall == int'(e.waits) && !low_any1 && !low_rdnz && rd == e.data;
            if (!ok) begin
              fails++;
              $display("FAIL dphase_%0d: got resp=%b stall=%0d low_resp_any=%b rdata=%h, required resp=%b stall=%0d rdata=%h",
                       n_done, rs, stall, low_any1, rd, e.err, e.err ? 1 : int'(e.waits), e.data);
            end
          end
          n_done++;
        end
      end else begin
        tests++;
        if (!(ro0 && ro3 && !rsp0 && !rsp3 && rd0 == 32'h0 && rd3 == 32'h0)) begin
          fails++;
          $display("FAIL idle_outputs: got ready=%b/%b resp=%b/%b rdata=%h/%h, required ready=1 resp=0 rdata=0",
                   ro0, ro3, rsp0, rsp3, rd0, rd3);
        end
      end
      if ((sel0 || sel3) && trans[1] && ready) begin
        in_dp    = 1'b1;
        dsel     = sel3;
        stall    = 0;
        low_all1 = 1'b1;
        low_any1 = 1'b0;
        low_rdnz = 1'b0;
      end
    end
  end

  task automatic wait_ready();
    logic r;
    int   n;
    r = 1'b0;
    n = 0;
    while (!r && n < 50) begin
      @(negedge clk);
      r = ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!r) begin
      tests++;
      fails++;
      $display("FAIL wait_ready_timeout: got ready=%b after %0d cycles, required 1", r, n);
    end
  endtask

  task automatic xfer(input logic tgt3, input logic wr, input logic [31:0] a, input logic [2:0] sz,
                      input logic [31:0] wd, input logic [3:0] st, input logic err, input logic [31:0] rexp);
    exp_t e;
    e.err   = err;
    e.data  = (wr || err) ? 32'h0 : rexp;
    e.waits = tgt3 ? 4'd3 : 4'd0;
    q.push_back(e);
    sel0  = !tgt3;
    sel3  = tgt3;
    addr  = a;
    write = wr;
    size  = sz;
    trans = 2'd2;
    wait_ready();
    wdata = wd;
    wstrb = st;
  endtask

  task automatic idle(input int n);
    sel0  = 1'b0;
    sel3  = 1'b0;
    trans = 2'd0;
    wait_ready();
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of run, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    sel0  = 1'b0;
    sel3  = 1'b0;
    addr  = 32'h0;
    write = 1'b0;
    size  = 3'd2;
    trans = 2'd0;
    wdata = 32'h0;
    wstrb = 4'h0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Basic, byte-strobe and halfword writes on the zero-wait subordinate.
    xfer(0, 1, 32'h10, 3'd2, 32'hDEADBEEF, 4'hF, 0, 32'h0);
    idle(1);
    xfer(0, 0, 32'h10, 3'd2, 32'h0, 4'h0, 0, 32'hDEADBEEF);
    idle(1);
    xfer(0, 1, 32'h10, 3'd2, 32'h000000AA, 4'b0001, 0, 32'h0);
    xfer(0, 0, 32'h10, 3'd2, 32'h0, 4'h0, 0, 32'hDEADBEAA);
    xfer(0, 1, 32'h12, 3'd1, 32'h55550000, 4'b1100, 0, 32'h0);
    xfer(0, 0, 32'h10, 3'd2, 32'h0, 4'h0, 0, 32'h5555BEAA);
    xfer(0, 1, 32'h3FC, 3'd2, 32'hA5A5A5A5, 4'hF, 0, 32'h0);
    xfer(0, 0, 32'h3FC, 3'd2, 32'h0, 4'h0, 0, 32'hA5A5A5A5);
    idle(2);

    // Illegal accesses leave word 0 untouched.
    xfer(0, 1, 32'h0, 3'd2, 32'hCAFEF00D, 4'hF, 0, 32'h0);
    idle(1);
    xfer(0, 1, 32'h400, 3'd2, 32'hFFFFFFFF, 4'hF, 1, 32'h0);
    xfer(0, 1, 32'h0, 3'd3, 32'hFFFFFFFF, 4'hF, 1, 32'h0);
    xfer(0, 1, 32'h2, 3'd2, 32'hFFFFFFFF, 4'hF, 1, 32'h0);
    xfer(0, 0, 32'h0, 3'd3, 32'h0, 4'h0, 1, 32'h0);
    idle(1);
    xfer(0, 0, 32'h0, 3'd2, 32'h0, 4'h0, 0, 32'hCAFEF00D);
    idle(2);

    // Write immediately followed by a read of the same word.
    xfer(0, 1, 32'h4, 3'd2, 32'h11111111, 4'hF, 0, 32'h0);
    xfer(0, 0, 32'h4, 3'd2, 32'h0, 4'h0, 0, 32'h11111111);
    idle(2);

    // Three-wait-state subordinate.
    xfer(1, 1, 32'h20, 3'd2, 32'h12345678, 4'hF, 0, 32'h0);
    xfer(1, 0, 32'h20, 3'd2, 32'h0, 4'h0, 0, 32'h12345678);
    xfer(1, 1, 32'h20, 3'd3, 32'hFFFFFFFF, 4'hF, 1, 32'h0);
    idle(2);

    // Reset during WAIT of a write drops it.
    xfer(1, 1, 32'h8, 3'd2, 32'h0, 4'hF, 0, 32'h0);
    idle(2);
    xfer(1, 1, 32'h8, 3'd2, 32'hFFFFFFFF, 4'hF, 0, 32'h0);
    sel0  = 1'b0;
    sel3  = 1'b0;
    trans = 2'd0;
    #2 reset = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 reset = 1'b0;
    xfer(1, 0, 32'h8, 3'd2, 32'h0, 4'h0, 0, 32'h0);
    xfer(1, 0, 32'h20, 3'd2, 32'h0, 4'h0, 0, 32'h12345678);
    idle(5);

    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ahb_sram_sub.md
# ahb_sram_sub

AHB subordinate holding a word-addressed register-file memory. It consumes the manager-driven signals of the common AHB bus (address, control and write data), and produces the subordinate response (`readyOut`, `resp`, `rData`) that feeds the response mux. It supports a parameterised number of wait states, byte-strobed writes and two-cycle ERROR responses for illegal accesses. It is the default memory target for bus bring-up and interconnect verification.

## Interface
- `DataWidth`, 32, data bus width in bits; must be 32 or 64.
- `AddrWidth`, 32, address bus width in bits.
- `Depth`, 256, number of `DataWidth` words; power of two.
- `WaitStates`, 0, wait cycles inserted in every non-error data phase; range 0–15.

- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `sel` in 1: select from the address decoder, sampled in the address phase.
- `addr` in AddrWidth: byte address.
- `write` in 1: 1 for write, 0 for read.
- `size` in 3: log2 of the transfer bytes.
- `trans` in 2: transfer type. 0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ.
- `ready` in 1: bus-level HREADY. Qualifies the address phase.
- `wData` in DataWidth: write data, valid in the data phase.
- `wStrb` in DataWidth/8: write byte strobes, valid in the data phase.
- `readyOut` out 1: completion of this subordinate's data phase.
- `resp` out 1: 1 for ERROR, 0 for OKAY.
- `rData` out DataWidth: read data.

## Operation
- **Address phase accept:** occurs when `sel && ready && trans[1]`. On accept, register `addr`, `write` and `size`, and the legality result.
- **Illegal access:** any of the following makes the access illegal:
  - `size > log2(DataWidth/8)`;
  - `addr` not aligned to `1<<size`;
  - word index `addr >> log2(DataWidth/8)` is `>= Depth`.
- **IDLE, BUSY or no `sel`:** no state change. The data phase that follows gives a zero-wait OKAY.
- **FSM states:**
  - IDLE: default state. Outputs `readyOut=1`, `resp=0`.
  - WAIT: counter runs from `WaitStates` down to 1. Outputs `readyOut=0`, `resp=0`.
  - XFER: final cycle of a legal data phase. Outputs `readyOut=1`, `resp=0`.
  - ERR1: first ERROR cycle. Outputs `readyOut=0`, `resp=1`.
  - ERR2: second ERROR cycle. Outputs `readyOut=1`, `resp=1`.
- **Transitions on accept:**
  - Legal access with `WaitStates>0` goes to WAIT.
  - Legal access with `WaitStates=0` goes to XFER.
  - Illegal access goes to ERR1.
- **Remaining transitions:**
  - WAIT goes to XFER when the counter reaches 1.
  - ERR1 always goes to ERR2.
  - XFER and ERR2 go to IDLE. If a new accept occurs in that same cycle, they go directly to that accept's target state (back-to-back pipelining).
- **Write commit:** on the rising edge ending XFER, apply `wData` to the registered word for every byte lane where `wStrb[i]=1`. Erroring writes never modify memory.
- **Read data:**
  - In XFER of a read, `rData` equals `mem[registered word index]`, read combinationally from the array.
  - In all other states `rData` is 0.
- **Address phase during ERR1:** it is ignored, because `ready` is low bus-wide. The manager re-presents the address phase after ERR2.

## Timing
- **Reset values:**
  - `readyOut=1`, `resp=0`, `rData=0`;
  - FSM in IDLE, wait counter 0.
  - Memory contents are not reset.
- **Reset mid-transfer:** asserting `reset` in any state returns to IDLE immediately (asynchronous). Any write in flight is dropped.
- **Read latency:** with address phase in cycle N, `rData` is valid and `readyOut=1` in cycle N+1+WaitStates.
- **Write latency:** memory is updated at the end of cycle N+1+WaitStates.
- **Write-then-read hazard:** a read whose address phase overlaps a write's XFER cycle to the same word returns the newly written data. The write commits on the edge before the read's data phase.
- **ERROR timing:** ERR1 falls in cycle N+1 and ERR2 in cycle N+2, regardless of `WaitStates`.
- **Throughput:** with `WaitStates=0`, back-to-back NONSEQ/SEQ accesses complete one per cycle.

## Test plan
- **Basic write/read:** reset, then write 0xDEADBEEF to 0x10 with full strobes, then read 0x10. Required: read returns 0xDEADBEEF, `resp=0`, `readyOut=1` in cycle N+1.
- **Byte strobes:** starting from 0xDEADBEEF at 0x10, write 0x000000AA to 0x10 with `wStrb=4'b0001`, then read. Required: read returns 0xDEADBEAA.
- **Wait states:** with `WaitStates=3`, read 0x20. Required: `readyOut` is low for cycles N+1..N+3, and data plus `readyOut=1` arrive in N+4.
- **Errors:** each of the following gives ERR1 (`readyOut=0`, `resp=1`) then ERR2 (`readyOut=1`, `resp=1`), and memory at 0x00 is unchanged:
  - write to word index `Depth` (byte 0x400 for Depth 256, DataWidth 32);
  - `size=3` on a 32-bit bus;
  - `size=2` access at 0x02.
- **Pipelining:** NONSEQ write to 0x4 (0x11111111) followed immediately by NONSEQ read of 0x4, then IDLE. Required: read returns 0x11111111 and there are no stall cycles.
- **Reset mid-operation:** with `WaitStates=3`, assert `reset` during WAIT of a write to 0x8 holding 0x0. Required: `readyOut=1` and `resp=0` immediately, and a later read of 0x8 returns 0x0.
